// File: rtl/sram_pkg.sv
// Shared types and elaboration-time helpers for the byte-lane SRAM with a clear sequencer.
package sram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int num_lanes(input int data_width, input int lane_width);
      return (lane_width > 0) ? data_width / lane_width : 1;
   endfunction

   function automatic bit lanes_legal(input int data_width, input int lane_width);
      return (lane_width > 0) && (data_width % lane_width == 0);
   endfunction

   function automatic bit latency_legal(input int rd_latency);
      return (rd_latency == 1) || (rd_latency == 2);
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Clear sequencer: walks every address once after reset or on request, owning the
// array write port while busy.
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_req,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr,
   output logic                  init_busy
);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      init_busy = 1'b0;
      init_we   = 1'b0;
      init_addr = cnt;
      case (state)
         ST_INIT: begin
            init_busy = 1'b1;
            init_we   = 1'b1;
            cnt_nxt   = cnt + ADDR_WIDTH'(1);
            if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (init_req) begin
               state_nxt = ST_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/sram_be_init.sv
// Single-port SRAM with per-lane write enables, write-first reads, a 1- or 2-stage
// registered read pipe and a hardware clear sequence.
module sram_be_init
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 14,
   parameter int                    ADDR_WIDTH = 13,
   parameter int                    LANE_WIDTH = 7,
   parameter int                    RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ADDR_WIDTH-1:0]            a,
   input  logic [DATA_WIDTH-1:0]            wd,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] be,
   input  logic                             write,
   input  logic                             read,
   input  logic                             init_req,
   output logic [DATA_WIDTH-1:0]            rd,
   output logic                             rd_valid,
   output logic                             init_busy
);

   localparam int NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH);
   localparam int ENTRIES   = 2 ** ADDR_WIDTH;

   if (!lanes_legal(DATA_WIDTH, LANE_WIDTH)) begin : g_bad_lanes
      $error("sram_be_init: DATA_WIDTH must be a multiple of LANE_WIDTH");
   end
   if (!latency_legal(RD_LATENCY)) begin : g_bad_latency
      $error("sram_be_init: RD_LATENCY must be 1 or 2");
   end

   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;

   sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_req  (init_req),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_busy (init_busy)
   );

   logic [DATA_WIDTH-1:0] ram [ENTRIES];
   logic [DATA_WIDTH-1:0] ram_word, merged;
   logic                  wr_acc, rd_acc;

   assign wr_acc   = write & ~init_busy;
   assign rd_acc   = read & ~init_busy;
   assign ram_word = ram[a];

   // The merged word is both the new array value and the write-first read value.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign merged[i*LANE_WIDTH +: LANE_WIDTH] = (wr_acc && be[i]) ?
         wd[i*LANE_WIDTH +: LANE_WIDTH] : ram_word[i*LANE_WIDTH +: LANE_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (init_we)     ram[init_addr] <= INIT_VALUE;
      else if (wr_acc) ram[a]         <= merged;
   end

   logic                  st_vld;
   logic [DATA_WIDTH-1:0] st_data;

   // Latency 2 captures the array word here; later writes are not forwarded.
   if (RD_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_vld  <= 1'b0;
            st_data <= '0;
         end else begin
            st_vld <= rd_acc;
            if (rd_acc) st_data <= merged;
         end
      end
   end else begin : g_lat1
      assign st_vld  = rd_acc;
      assign st_data = merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd       <= '0;
      end else begin
         rd_valid <= st_vld;
         if (st_vld) rd <= st_data;
      end
   end

endmodule
